// File: rtl/dma_wr_arbiter.sv
// Round-robin arbiter sharing one DMA write channel (command + data) among
// NUM_PORTS requesters; the data path stays locked to the winner until its last beat.
module dma_wr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 64,
    parameter int LEN_W     = 32,
    parameter int DATA_W    = 512,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                          pcie_clk,
    input  logic                          pcie_aresetn,

    input  logic [NUM_PORTS-1:0]          s_cmd_valid,
    output logic [NUM_PORTS-1:0]          s_cmd_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0]   s_cmd_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]    s_cmd_len,

    input  logic [NUM_PORTS-1:0]          s_data_valid,
    output logic [NUM_PORTS-1:0]          s_data_ready,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_data_data,
    input  logic [NUM_PORTS*DATA_W/8-1:0] s_data_keep,
    input  logic [NUM_PORTS-1:0]          s_data_last,

    output logic                          m_cmd_valid,
    input  logic                          m_cmd_ready,
    output logic [ADDR_W-1:0]             m_cmd_addr,
    output logic [LEN_W-1:0]              m_cmd_len,

    output logic                          m_data_valid,
    input  logic                          m_data_ready,
    output logic [DATA_W-1:0]             m_data_data,
    output logic [DATA_W/8-1:0]           m_data_keep,
    output logic                          m_data_last,

    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy,
    output logic [31:0]                   cmd_cnt
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int unsigned NP = NUM_PORTS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     grant_idx_q;
    logic                 cmd_act_q;
    logic                 data_act_q;
    logic                 busy_q;
    logic [31:0]          cmd_cnt_q;

    logic [IDX_W-1:0]     pick_idx_d;
    logic                 pick_found_d;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic                 g_data_valid;
    logic                 g_data_last;
    logic                 data_done;

    function automatic logic [IDX_W-1:0] wrap_add(
        input logic [IDX_W-1:0] a,
        input int unsigned      b
    );
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NP) s = s - NP;
        return s[IDX_W-1:0];
    endfunction

    // Scan downward so the lowest offset from rr_ptr is the last (winning) write.
    always_comb begin
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (s_cmd_valid[wrap_add(rr_ptr_q, i)]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = wrap_add(rr_ptr_q, i);
            end
        end
    end

    always_comb begin
        m_cmd_addr   = '0;
        m_cmd_len    = '0;
        m_data_data  = '0;
        m_data_keep  = '0;
        g_data_valid = 1'b0;
        g_data_last  = 1'b0;
        gnt_oh       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                gnt_oh[i]    = 1'b1;
                m_cmd_addr   = s_cmd_addr[i*ADDR_W +: ADDR_W];
                m_cmd_len    = s_cmd_len[i*LEN_W +: LEN_W];
                m_data_data  = s_data_data[i*DATA_W +: DATA_W];
                m_data_keep  = s_data_keep[i*KEEP_W +: KEEP_W];
                g_data_valid = s_data_valid[i];
                g_data_last  = s_data_last[i];
            end
        end
    end

    assign s_cmd_ready  = gnt_oh & {NUM_PORTS{cmd_act_q & m_cmd_ready}};
    assign s_data_ready = gnt_oh & {NUM_PORTS{data_act_q & m_data_ready}};
    assign m_cmd_valid  = cmd_act_q;
    assign m_data_valid = data_act_q & g_data_valid;
    assign m_data_last  = g_data_last;
    assign grant_idx    = grant_idx_q;
    assign busy         = busy_q;
    assign cmd_cnt      = cmd_cnt_q;
    assign data_done    = g_data_valid & m_data_ready & g_data_last;

    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            cmd_act_q   <= 1'b0;
            data_act_q  <= 1'b0;
            busy_q      <= 1'b0;
            cmd_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        grant_idx_q <= pick_idx_d;
                        state_q     <= CMD;
                        cmd_act_q   <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                CMD: begin
                    if (m_cmd_ready) begin
                        cmd_cnt_q <= cmd_cnt_q + 32'd1;
                        rr_ptr_q  <= wrap_add(grant_idx_q, 1);
                        cmd_act_q <= 1'b0;
                        // Zero-length commands carry no data phase.
                        if (m_cmd_len != '0) begin
                            state_q    <= DATA;
                            data_act_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (data_done) begin
                        state_q    <= IDLE;
                        data_act_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cmd_act_q  <= 1'b0;
                    data_act_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// Randomised requesters and DMA back-pressure checked against a
// transaction-level round-robin model, including a reset mid-transfer.
module tb_dma_wr_arbiter;

    localparam int NP = 4;
    localparam int AW = 64;
    localparam int LW = 32;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    s_cmd_valid, s_cmd_ready;
    logic [NP*AW-1:0] s_cmd_addr;
    logic [NP*LW-1:0] s_cmd_len;
    logic [NP-1:0]    s_data_valid, s_data_ready, s_data_last;
    logic [NP*DW-1:0] s_data_data;
    logic [NP*KW-1:0] s_data_keep;
    logic             m_cmd_valid, m_cmd_ready;
    logic [AW-1:0]    m_cmd_addr;
    logic [LW-1:0]    m_cmd_len;
    logic             m_data_valid, m_data_ready, m_data_last;
    logic [DW-1:0]    m_data_data;
    logic [KW-1:0]    m_data_keep;
    logic [IW-1:0]    grant_idx;
    logic             busy;
    logic [31:0]      cmd_cnt;

    always #5 clk = ~clk;

    dma_wr_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .IDX_W(IW)
    ) dut (
        .pcie_clk(clk), .pcie_aresetn(rst_n),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
        .s_data_data(s_data_data), .s_data_keep(s_data_keep),
        .s_data_last(s_data_last),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
        .m_data_data(m_data_data), .m_data_keep(m_data_keep),
        .m_data_last(m_data_last),
        .grant_idx(grant_idx), .busy(busy), .cmd_cnt(cmd_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester side
    bit          pend[NP];
    bit          acc[NP];
    bit          dv[NP];
    logic [63:0] r_addr[NP];
    logic [31:0] r_len[NP];
    int          r_beats[NP], r_beat[NP], r_seq[NP], waitg[NP];
    int          stall_left;

    // Transaction-level arbiter model
    bit          f_cmd, f_data;
    int          own, rr;
    logic [31:0] cnt_e;

    function automatic logic [DW-1:0] mk_data(input int p, input int s, input int b);
        logic [31:0] w;
        w = {p[7:0], s[7:0], b[15:0]};
        return {16{w}};
    endfunction

    function automatic logic [KW-1:0] mk_keep(input int p);
        logic [KW-1:0] one;
        int nb;
        one = 1;
        if (r_beat[p] < r_beats[p] - 1) return '1;
        nb = int'(r_len[p]) - (r_beats[p] - 1) * 64;
        if (nb >= 64) return '1;
        return (one << nb) - one;
    endfunction

    task automatic clear_all();
        for (int p = 0; p < NP; p++) begin
            pend[p] = 0; acc[p] = 0; dv[p] = 0;
            r_addr[p] = '0; r_len[p] = '0;
            r_beats[p] = 0; r_beat[p] = 0; waitg[p] = 0;
        end
        f_cmd = 0; f_data = 0; own = 0; rr = 0; cnt_e = '0;
        stall_left = 0;
    endtask

    task automatic drive(input bit quiet);
        int b;
        for (int p = 0; p < NP; p++) begin
            if (!quiet && !pend[p] && !acc[p] && $urandom_range(3) == 0) begin
                b = int'($urandom_range(0, 4));
                pend[p]    = 1;
                r_addr[p]  = {$urandom, $urandom};
                r_len[p]   = (b == 0) ? 32'd0 :
                             32'(b * 64 - int'($urandom_range(0, 63)));
                r_beats[p] = b;
                r_beat[p]  = 0;
                r_seq[p]   = r_seq[p] + 1;
                waitg[p]   = 0;
            end
            dv[p] = (pend[p] || acc[p]) && ($urandom_range(1) == 1);
            s_cmd_valid[p]          = pend[p];
            s_cmd_addr[p*AW +: AW]  = r_addr[p];
            s_cmd_len[p*LW +: LW]   = r_len[p];
            s_data_valid[p]         = dv[p];
            s_data_data[p*DW +: DW] = mk_data(p, r_seq[p], r_beat[p]);
            s_data_keep[p*KW +: KW] = mk_keep(p);
            s_data_last[p]          = (r_beat[p] == r_beats[p] - 1);
        end
        if (stall_left > 0) begin
            m_cmd_ready = 0;
            stall_left--;
        end else if ($urandom_range(15) == 0) begin
            m_cmd_ready = 0;
            stall_left = 10;
        end else begin
            m_cmd_ready = ($urandom_range(3) != 0);
        end
        m_data_ready = $urandom_range(1) == 1;
    endtask

    task automatic check_outputs();
        logic [NP-1:0] e_cr, e_dr;
        bit e_dv;
        e_cr = '0;
        e_dr = '0;
        if (f_cmd && m_cmd_ready) e_cr[own] = 1'b1;
        if (f_data && m_data_ready) e_dr[own] = 1'b1;
        e_dv = f_data && dv[own];
        chk("m_cmd_valid", DW'(m_cmd_valid), DW'(f_cmd));
        chk("busy", DW'(busy), DW'(f_cmd | f_data));
        chk("s_cmd_ready", DW'(s_cmd_ready), DW'(e_cr));
        chk("m_data_valid", DW'(m_data_valid), DW'(e_dv));
        chk("s_data_ready", DW'(s_data_ready), DW'(e_dr));
        chk("cmd_cnt", DW'(cmd_cnt), DW'(cnt_e));
        if (f_cmd) begin
            chk("grant_idx", DW'(grant_idx), DW'(own));
            chk("m_cmd_addr", DW'(m_cmd_addr), DW'(r_addr[own]));
            chk("m_cmd_len", DW'(m_cmd_len), DW'(r_len[own]));
        end
        if (e_dv) begin
            chk("m_data_data", m_data_data, mk_data(own, r_seq[own], r_beat[own]));
            chk("m_data_keep", DW'(m_data_keep), DW'(mk_keep(own)));
            chk("m_data_last", DW'(m_data_last),
                DW'(r_beat[own] == r_beats[own] - 1));
        end
    endtask

    // Advance the model across the coming clock edge.
    task automatic advance();
        bit found;
        int p;
        found = 0;
        if (!f_cmd && !f_data) begin
            for (int k = 0; k < NP; k++) begin
                p = (rr + k) % NP;
                if (pend[p] && !found) begin
                    found = 1;
                    own = p;
                end
            end
            if (found) begin
                f_cmd = 1;
                chk("fairness_wait", DW'(waitg[own] <= NP - 1), DW'(1));
                for (int q = 0; q < NP; q++)
                    if (q != own && pend[q]) waitg[q]++;
            end
        end else if (f_cmd) begin
            if (m_cmd_ready) begin
                cnt_e = cnt_e + 32'd1;
                rr = (own + 1) % NP;
                pend[own] = 0;
                f_cmd = 0;
                if (r_len[own] != 0) begin
                    acc[own] = 1;
                    f_data = 1;
                end
            end
        end else if (dv[own] && m_data_ready) begin
            if (r_beat[own] == r_beats[own] - 1) begin
                acc[own] = 0;
                f_data = 0;
            end else begin
                r_beat[own]++;
            end
        end
    endtask

    initial begin
        bit armed, rst_done;
        armed = 0;
        rst_done = 0;
        for (int p = 0; p < NP; p++) r_seq[p] = 0;
        clear_all();
        drive(1'b1);
        #12;
        chk("rst_m_cmd_valid", DW'(m_cmd_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_cmd_cnt", DW'(cmd_cnt), DW'(0));
        chk("rst_grant_idx", DW'(grant_idx), DW'(0));
        chk("rst_s_cmd_ready", DW'(s_cmd_ready), DW'(0));
        chk("rst_s_data_ready", DW'(s_data_ready), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 1500) armed = 1;
            if (armed && f_data && r_beat[own] >= 2) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_m_data_valid", DW'(m_data_valid), DW'(0));
                chk("midrst_busy", DW'(busy), DW'(0));
                chk("midrst_cmd_cnt", DW'(cmd_cnt), DW'(0));
                chk("midrst_s_data_ready", DW'(s_data_ready), DW'(0));
                chk("midrst_grant_idx", DW'(grant_idx), DW'(0));
                clear_all();
                drive(1'b1);
                @(negedge clk);
                rst_n = 1'b1;
                armed = 0;
                rst_done = 1;
            end else begin
                drive(1'b0);
                #1;
                check_outputs();
                advance();
            end
        end
        chk("midrst_reached", DW'(rst_done), DW'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_wr_arbiter.md
Name: dma_wr_arbiter

Overview:
Shares one DMA write channel between NUM_PORTS requesters. The channel is a command stream (address/length) plus a 512-bit data stream.
- Grants one requester at a time, rotating priority.
- Forwards that requester's command to the DMA engine, then locks the data path to it until its last data beat is accepted.
- Sits between user kernels and the DMA interface write-command/write-data ports, all in the PCIe clock domain.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
ADDR_W, 64, command address width
LEN_W, 32, command length width (bytes)
DATA_W, 512, data beat width; keep width = DATA_W/8
IDX_W, $clog2(NUM_PORTS), grant index width

Ports:
pcie_clk  in  1  clock
pcie_aresetn  in  1  asynchronous active-low reset
s_cmd_valid  in  NUM_PORTS  per-requester command valid
s_cmd_ready  out  NUM_PORTS  per-requester command ready
s_cmd_addr  in  NUM_PORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
s_cmd_len  in  NUM_PORTS*LEN_W  packed lengths
s_data_valid  in  NUM_PORTS  per-requester data valid
s_data_ready  out  NUM_PORTS  per-requester data ready
s_data_data  in  NUM_PORTS*DATA_W  packed data
s_data_keep  in  NUM_PORTS*DATA_W/8  packed keep
s_data_last  in  NUM_PORTS  per-requester last
m_cmd_valid  out  1  command to DMA
m_cmd_ready  in  1  DMA command ready
m_cmd_addr  out  ADDR_W  granted address
m_cmd_len  out  LEN_W  granted length
m_data_valid  out  1  data to DMA
m_data_ready  in  1  DMA data ready
m_data_data  out  DATA_W  granted data
m_data_keep  out  DATA_W/8  granted keep
m_data_last  out  1  granted last
grant_idx  out  IDX_W  current/last granted port
busy  out  1  state != IDLE
cmd_cnt  out  32  total commands issued

Behaviour:
- Reset (async, active-low): state=IDLE, rr_ptr=0, grant_idx=0, cmd_cnt=0. All m_*_valid, s_*_ready and busy = 0. Reset mid-transfer aborts immediately with no flush; data beats already accepted are the DMA side's concern.
- States: IDLE, CMD, DATA. One-hot or binary, implementer's choice.
- IDLE:
  - If any s_cmd_valid, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_PORTS.
  - Register the result into grant_idx; next state CMD.
  - No valid: stay in IDLE.
- CMD:
  - m_cmd_valid=1; m_cmd_addr/len = s_cmd_* of grant_idx.
  - s_cmd_ready[grant_idx]=m_cmd_ready; all other s_cmd_ready=0.
  - On handshake: cmd_cnt+=1 (wraps at 2^32) and rr_ptr=(grant_idx+1) mod NUM_PORTS.
  - After handshake, next state is DATA if len!=0, else IDLE (no data phase for zero length).
- DATA:
  - m_data_* = s_data_* of grant_idx; m_data_valid = s_data_valid[grant_idx].
  - s_data_ready[grant_idx]=m_data_ready; others 0.
  - The arbiter does not count beats; termination is requester-driven.
  - Handshake with s_data_last[grant_idx]=1 -> IDLE.
- Requesters must hold cmd valid/addr/len stable until ready, per AXI-Stream rules. Deasserting s_cmd_valid in CMD is illegal; the arbiter still presents the command.
- Outside CMD: m_cmd_valid=0, s_cmd_ready=0. Outside DATA: m_data_valid=0, s_data_ready=0.
- Data valid from non-granted ports is ignored; their data must not reach m_data_*.
- Latency:
  - s_cmd_valid rising in IDLE -> m_cmd_valid high the next cycle.
  - Last data handshake -> next m_cmd_valid no earlier than 2 cycles later (IDLE, then CMD).
- All m_* payload outputs are pure muxes of registered grant_idx; no combinational path from s_cmd_valid to m_cmd_valid.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 other grants.

Test Plan:
1. Single port 2 requests addr=0x1000, len=128; m_cmd_ready=1, m_data_ready=1 -> m_cmd_addr=0x1000, len=128 one cycle after request; 2 beats forwarded; IDLE after last; cmd_cnt=1; grant_idx=2.
2. All 4 ports request continuously, each len=64 (1 beat) -> grant order 0,1,2,3,0,…; no port granted twice before others; cmd_cnt=8 after 8 commands.
3. Port 1 in DATA phase (len=256); port 0 asserts s_data_valid throughout -> s_data_ready[0] stays 0; only port 1 data on m_data_*; m_data_ready toggled 50% -> all 4 beats pass in order.
4. Port 3 len=0 -> one cmd handshake, no data phase; returns to IDLE; port 0 granted next (rr_ptr wrap 3->0).
5. Assert pcie_aresetn=0 mid-DATA after beat 2 of 4 -> same cycle: m_data_valid=0, busy=0, cmd_cnt=0. After release, a new request is granted from port 0 priority.
6. m_cmd_ready held 0 for 10 cycles in CMD -> m_cmd_valid stays 1 with stable addr/len; s_cmd_ready all 0; handshake on the cycle ready rises.
